// File: rtl/core_launch_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : core_launch_ctrl_pkg
// Brief    : Shared state encoding and run-counter definitions for the launcher.
// Revision : 1.0 - initial release
// ============================================================================
package core_launch_ctrl_pkg;

    localparam int c_COUNT_W = 32;
    typedef logic [c_COUNT_W-1:0] count_t;
    localparam count_t c_COUNT_MAX = '1;

    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_HOLD   = 3'd1;
    localparam state_t c_ST_LAUNCH = 3'd2;
    localparam state_t c_ST_RUN    = 3'd3;
    localparam state_t c_ST_END    = 3'd4;

    function automatic count_t sat_inc(input count_t value);
        return (value == c_COUNT_MAX) ? value : value + count_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_launch_ctrl_stall_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stall_pattern_gen
// Brief    : Periodic stall window; stall is raised for the first STALL_LEN
//            cycles of each STALL_PERIOD window, phase restarting on run entry.
// Revision : 1.0 - initial release
// ============================================================================
module stall_pattern_gen #(
    parameter int STALL_PERIOD = 8,
    parameter int STALL_LEN    = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic stall_en,
    output logic core_stall
);

    localparam int c_PHASE_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    logic [c_PHASE_W-1:0] r_phase;
    logic                 w_phase_last;

    assign w_phase_last = (r_phase == c_PHASE_W'(STALL_PERIOD - 1));

    // Phase is held at zero outside the run so every run starts a fresh window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (!run || w_phase_last) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + c_PHASE_W'(1);
        end
    end

    assign core_stall = run && stall_en && (r_phase < c_PHASE_W'(STALL_LEN));

endmodule
`default_nettype wire

// File: rtl/core_launch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : core_launch_ctrl
// Brief    : Holds cores in reset, issues staggered start pulses, supervises
//            the run for completion or timeout and reports the run length.
// Revision : 1.0 - initial release
// ============================================================================
module core_launch_ctrl
    import core_launch_ctrl_pkg::*;
#(
    parameter int NUM_CORES      = 2,
    parameter int ADDRESS_BITS   = 20,
    parameter int RESET_CYCLES   = 4,
    parameter int STAGGER_CYCLES = 0,
    parameter int STALL_PERIOD   = 8,
    parameter int STALL_LEN      = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    go,
    input  logic [ADDRESS_BITS-1:0] boot_address,
    input  logic                    stall_en,
    input  logic [NUM_CORES-1:0]    core_done,
    output logic [NUM_CORES-1:0]    core_reset,
    output logic [NUM_CORES-1:0]    core_start,
    output logic                    core_stall,
    output logic [ADDRESS_BITS-1:0] prog_address,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic                    report,
    output logic [31:0]             cycle_count
);

    localparam int c_CORE_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int c_CNT_MAX = (RESET_CYCLES > STAGGER_CYCLES) ? RESET_CYCLES : STAGGER_CYCLES + 1;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CORE_W-1:0]  c_LAST_CORE = c_CORE_W'(NUM_CORES - 1);
    localparam logic [NUM_CORES-1:0] c_ONE_HOT0  = NUM_CORES'(1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CORE_W-1:0]     r_core;
    logic [ADDRESS_BITS-1:0] r_prog_address;
    logic                    r_done;
    logic                    r_timeout;
    count_t                  r_cycle_count;
    logic [NUM_CORES-1:0]    r_done_mask;

    logic [NUM_CORES-1:0]    w_mask_next;
    count_t                  w_count_next;
    logic                    w_timeout_hit;
    logic                    w_launch_fire;
    logic                    w_last_core;
    logic [NUM_CORES-1:0]    w_core_reset;
    logic [NUM_CORES-1:0]    w_core_start;
    logic                    w_report;
    logic                    w_accept;
    logic                    w_finish_done;
    logic                    w_finish_timeout;
    logic                    w_run;

    assign w_mask_next   = r_done_mask | core_done;
    assign w_count_next  = sat_inc(r_cycle_count);
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (w_count_next == count_t'(TIMEOUT_CYCLES));
    assign w_launch_fire = (r_cnt == '0);
    assign w_last_core   = (r_core == c_LAST_CORE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_core_reset     = '0;
        w_core_start     = '0;
        w_report         = 1'b0;
        w_accept         = 1'b0;
        w_finish_done    = 1'b0;
        w_finish_timeout = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_core_reset = '1;
                if (go) begin
                    w_accept     = 1'b1;
                    w_state_next = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                w_core_reset = '1;
                if (r_cnt == c_CNT_W'(RESET_CYCLES - 1)) begin
                    w_state_next = c_ST_LAUNCH;
                end
            end
            c_ST_LAUNCH: begin
                if (w_launch_fire) begin
                    w_core_start = c_ONE_HOT0 << r_core;
                    if (w_last_core) begin
                        w_state_next = c_ST_RUN;
                    end
                end
            end
            c_ST_RUN: begin
                // Completion wins over a timeout landing on the same cycle.
                if (&w_mask_next) begin
                    w_finish_done = 1'b1;
                    w_state_next  = c_ST_END;
                end else if (w_timeout_hit) begin
                    w_finish_timeout = 1'b1;
                    w_state_next     = c_ST_END;
                end
            end
            c_ST_END: begin
                w_report     = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // r_cnt times the reset hold, then the gap between start pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_core <= '0;
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    r_cnt <= (w_state_next == c_ST_LAUNCH) ? '0 : r_cnt + c_CNT_W'(1);
                end
                c_ST_LAUNCH: begin
                    if (w_launch_fire && w_last_core) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_W'(STAGGER_CYCLES)) begin
                        r_cnt  <= '0;
                        r_core <= r_core + c_CORE_W'(1);
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    r_core <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prog_address <= '0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_cycle_count  <= '0;
            r_done_mask    <= '0;
        end else begin
            if (w_accept) begin
                r_prog_address <= boot_address;
                r_done         <= 1'b0;
                r_timeout      <= 1'b0;
                r_cycle_count  <= '0;
                r_done_mask    <= '0;
            end
            if (r_state == c_ST_RUN) begin
                r_cycle_count <= w_count_next;
            end
            if ((r_state == c_ST_LAUNCH) || (r_state == c_ST_RUN)) begin
                r_done_mask <= w_mask_next;
            end
            if (w_finish_done) begin
                r_done <= 1'b1;
            end
            if (w_finish_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_run = (r_state == c_ST_RUN);

    stall_pattern_gen #(
        .STALL_PERIOD (STALL_PERIOD),
        .STALL_LEN    (STALL_LEN)
    ) u_stall (
        .clock      (clock),
        .reset      (reset),
        .run        (w_run),
        .stall_en   (stall_en),
        .core_stall (core_stall)
    );

    assign core_reset   = w_core_reset;
    assign core_start   = w_core_start;
    assign prog_address = r_prog_address;
    assign busy         = (r_state != c_ST_IDLE);
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign report       = w_report;
    assign cycle_count  = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_core_launch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_core_launch_ctrl
// Brief    : Scoreboard bench for core_launch_ctrl (default and staggered/timeout builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_launch_ctrl;

    localparam int AW = 20;
    localparam logic [60:0] c_RESET_VIEW = {2'b11, 2'b00, 1'b0, {AW{1'b0}}, 4'b0000, 32'd0};

    typedef struct packed {
        logic [1:0]  crst;
        logic [1:0]  cstart;
        logic        stall;
        logic        busy;
        logic        report;
        logic [31:0] count;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          go_a, go_b, stall_en;
    logic [AW-1:0] boot_address;
    logic [1:0]    done_a, done_b;

    logic [1:0]    a_core_reset, a_core_start, b_core_reset, b_core_start;
    logic          a_core_stall, a_busy, a_done, a_timeout, a_report;
    logic          b_core_stall, b_busy, b_done, b_timeout, b_report;
    logic [AW-1:0] a_prog_address, b_prog_address;
    logic [31:0]   a_cycle_count, b_cycle_count;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q_exp[$];

    always #5 clock = ~clock;

    core_launch_ctrl #(.NUM_CORES(2), .ADDRESS_BITS(AW)) dut_a (
        .clock(clock), .reset(reset), .go(go_a), .boot_address(boot_address),
        .stall_en(stall_en), .core_done(done_a), .core_reset(a_core_reset),
        .core_start(a_core_start), .core_stall(a_core_stall), .prog_address(a_prog_address),
        .busy(a_busy), .done(a_done), .timeout(a_timeout), .report(a_report),
        .cycle_count(a_cycle_count)
    );

    core_launch_ctrl #(.NUM_CORES(2), .ADDRESS_BITS(AW), .STAGGER_CYCLES(3), .TIMEOUT_CYCLES(16)) dut_b (
        .clock(clock), .reset(reset), .go(go_b), .boot_address(boot_address),
        .stall_en(stall_en), .core_done(done_b), .core_reset(b_core_reset),
        .core_start(b_core_start), .core_stall(b_core_stall), .prog_address(b_prog_address),
        .busy(b_busy), .done(b_done), .timeout(b_timeout), .report(b_report),
        .cycle_count(b_cycle_count)
    );

    function automatic exp_t mk(input logic [1:0] crst, input logic [1:0] cstart, input logic stall,
                                input logic bsy, input logic rep, input int count);
        exp_t e;
        e.crst   = crst;
        e.cstart = cstart;
        e.stall  = stall;
        e.busy   = bsy;
        e.report = rep;
        e.count  = 32'(count);
        return e;
    endfunction

    // Reference model: 4 hold cycles, start pulses with 'stagger' gaps, then RUN.
    task automatic push_launch(input int stagger);
        logic [1:0] onehot;
        for (int i = 0; i < 4; i++) q_exp.push_back(mk(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 0));
        for (int c = 0; c < 2; c++) begin
            onehot = 2'b01 << c;
            q_exp.push_back(mk(2'b00, onehot, 1'b0, 1'b1, 1'b0, 0));
            if (c == 0)
                for (int s = 0; s < stagger; s++) q_exp.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 0));
        end
    endtask

    task automatic push_run(input int n_cycles, input bit stall_on);
        for (int n = 0; n < n_cycles; n++)
            q_exp.push_back(mk(2'b00, 2'b00, stall_on && ((n % 8) < 2), 1'b1, 1'b0, n));
    endtask

    task automatic push_end(input int count);
        q_exp.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, count));
        q_exp.push_back(mk(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, count));
    endtask

    task automatic test_reset();
        reset = 1'b1; go_a = 1'b0; go_b = 1'b0; stall_en = 1'b0;
        boot_address = '0; done_a = 2'b00; done_b = 2'b00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if ({a_core_reset, a_core_start, a_core_stall, a_prog_address, a_busy, a_done, a_timeout, a_report, a_cycle_count} !== c_RESET_VIEW) begin
            n_err++;
            $display("FAIL reset_a: got rst=%b start=%b busy=%b done=%b cnt=%0d, want reset values", a_core_reset, a_core_start, a_busy, a_done, a_cycle_count);
        end
        n_cmp++;
        if ({b_core_reset, b_core_start, b_core_stall, b_prog_address, b_busy, b_done, b_timeout, b_report, b_cycle_count} !== c_RESET_VIEW) begin
            n_err++;
            $display("FAIL reset_b: got rst=%b start=%b busy=%b done=%b cnt=%0d, want reset values", b_core_reset, b_core_start, b_busy, b_done, b_cycle_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_default_launch();
        exp_t e;
        stall_en = 1'b1;
        @(negedge clock);
        boot_address = 20'h00100;
        go_a = 1'b1;
        push_launch(0);
        for (int i = 0; q_exp.size() > 0; i++) begin
            @(negedge clock);
            go_a = 1'b0;
            e = q_exp.pop_front();
            n_cmp++;
            if ({a_core_reset, a_core_start, a_core_stall, a_busy, a_report, a_cycle_count} !== e) begin
                n_err++;
                $display("FAIL launch step %0d: got rst=%b start=%b stall=%b busy=%b rep=%b cnt=%0d, want rst=%b start=%b stall=%b busy=%b rep=%b cnt=%0d",
                         i, a_core_reset, a_core_start, a_core_stall, a_busy, a_report, a_cycle_count,
                         e.crst, e.cstart, e.stall, e.busy, e.report, e.count);
            end
        end
        n_cmp++;
        if (a_prog_address !== 20'h00100) begin
            n_err++;
            $display("FAIL launch prog_address: got %h want 00100", a_prog_address);
        end
    endtask

    task automatic test_completion();
        exp_t e;
        push_run(10, 1'b1);
        push_end(10);
        for (int i = 0; q_exp.size() > 0; i++) begin
            @(negedge clock);
            e = q_exp.pop_front();
            n_cmp++;
            if ({a_core_reset, a_core_start, a_core_stall, a_busy, a_report, a_cycle_count} !== e) begin
                n_err++;
                $display("FAIL completion run cycle %0d: got rst=%b start=%b stall=%b busy=%b rep=%b cnt=%0d, want rst=%b start=%b stall=%b busy=%b rep=%b cnt=%0d",
                         i, a_core_reset, a_core_start, a_core_stall, a_busy, a_report, a_cycle_count,
                         e.crst, e.cstart, e.stall, e.busy, e.report, e.count);
            end
            done_a = (i == 5) ? 2'b10 : (i == 9) ? 2'b01 : 2'b00;
        end
        n_cmp++;
        if ({a_done, a_timeout} !== 2'b10) begin
            n_err++;
            $display("FAIL completion status: got done=%b timeout=%b want done=1 timeout=0", a_done, a_timeout);
        end
    endtask

    task automatic test_stagger();
        exp_t e;
        int t0, t1;
        t0 = -1; t1 = -1;
        stall_en = 1'b0;
        @(negedge clock);
        boot_address = 20'h2A5A5;
        go_b = 1'b1;
        push_launch(3);
        for (int i = 0; q_exp.size() > 0; i++) begin
            @(negedge clock);
            go_b = 1'b0;
            if (b_core_start[0]) t0 = i;
            if (b_core_start[1]) t1 = i;
            e = q_exp.pop_front();
            n_cmp++;
            if ({b_core_reset, b_core_start, b_core_stall, b_busy, b_report, b_cycle_count} !== e) begin
                n_err++;
                $display("FAIL stagger step %0d: got rst=%b start=%b busy=%b cnt=%0d, want rst=%b start=%b busy=%b cnt=%0d",
                         i, b_core_reset, b_core_start, b_busy, b_cycle_count, e.crst, e.cstart, e.busy, e.count);
            end
        end
        n_cmp++;
        if (t1 - t0 != 4 || t0 < 0) begin
            n_err++;
            $display("FAIL stagger spacing: got %0d cycles want 4", t1 - t0);
        end
        n_cmp++;
        if (b_prog_address !== 20'h2A5A5) begin
            n_err++;
            $display("FAIL stagger prog_address: got %h want 2a5a5", b_prog_address);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        push_run(16, 1'b0);
        push_end(16);
        for (int i = 0; q_exp.size() > 0; i++) begin
            @(negedge clock);
            e = q_exp.pop_front();
            n_cmp++;
            if ({b_core_reset, b_core_start, b_core_stall, b_busy, b_report, b_cycle_count} !== e) begin
                n_err++;
                $display("FAIL timeout run cycle %0d: got busy=%b rep=%b cnt=%0d, want busy=%b rep=%b cnt=%0d",
                         i, b_busy, b_report, b_cycle_count, e.busy, e.report, e.count);
            end
        end
        n_cmp++;
        if ({b_done, b_timeout} !== 2'b01) begin
            n_err++;
            $display("FAIL timeout status: got done=%b timeout=%b want done=0 timeout=1", b_done, b_timeout);
        end
    endtask

    task automatic test_priority();
        exp_t e;
        int run0;
        run0 = 9;
        @(negedge clock);
        boot_address = 20'h0F00F;
        go_b = 1'b1;
        push_launch(3);
        push_run(16, 1'b0);
        push_end(16);
        for (int i = 0; q_exp.size() > 0; i++) begin
            @(negedge clock);
            go_b = 1'b0;
            e = q_exp.pop_front();
            n_cmp++;
            if ({b_core_reset, b_core_start, b_core_stall, b_busy, b_report, b_cycle_count} !== e) begin
                n_err++;
                $display("FAIL priority step %0d: got rst=%b start=%b busy=%b rep=%b cnt=%0d, want rst=%b start=%b busy=%b rep=%b cnt=%0d",
                         i, b_core_reset, b_core_start, b_busy, b_report, b_cycle_count,
                         e.crst, e.cstart, e.busy, e.report, e.count);
            end
            if (i == 0) begin
                n_cmp++;
                if (b_timeout !== 1'b0) begin
                    n_err++;
                    $display("FAIL priority timeout_clear: got %b want 0", b_timeout);
                end
            end
            done_b[0] = (i >= run0 + 3);
            done_b[1] = (i == run0 + 15);
        end
        done_b = 2'b00;
        n_cmp++;
        if ({b_done, b_timeout} !== 2'b10) begin
            n_err++;
            $display("FAIL priority status: got done=%b timeout=%b want done=1 timeout=0", b_done, b_timeout);
        end
    endtask

    task automatic test_go_while_busy();
        exp_t e;
        int run0;
        run0 = 6;
        stall_en = 1'b0;
        @(negedge clock);
        boot_address = 20'h0ABCD;
        go_a = 1'b1;
        push_launch(0);
        push_run(6, 1'b0);
        for (int i = 0; q_exp.size() > 0; i++) begin
            @(negedge clock);
            e = q_exp.pop_front();
            n_cmp++;
            if ({a_core_reset, a_core_start, a_core_stall, a_busy, a_report, a_cycle_count} !== e) begin
                n_err++;
                $display("FAIL go_busy step %0d: got rst=%b start=%b stall=%b busy=%b cnt=%0d, want rst=%b start=%b stall=%b busy=%b cnt=%0d",
                         i, a_core_reset, a_core_start, a_core_stall, a_busy, a_cycle_count,
                         e.crst, e.cstart, e.stall, e.busy, e.count);
            end
            go_a = (i == run0 + 2) || (i == run0 + 3);
            boot_address = (i >= run0 + 2) ? 20'h12345 : 20'h0ABCD;
        end
        n_cmp++;
        if (a_prog_address !== 20'h0ABCD) begin
            n_err++;
            $display("FAIL go_busy prog_address: got %h want 0abcd", a_prog_address);
        end
        n_cmp++;
        if (a_done !== 1'b0) begin
            n_err++;
            $display("FAIL go_busy done_clear: got %b want 0", a_done);
        end
    endtask

    task automatic test_midrun_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({a_core_reset, a_core_start, a_core_stall, a_prog_address, a_busy, a_done, a_timeout, a_report, a_cycle_count} !== c_RESET_VIEW) begin
            n_err++;
            $display("FAIL midrun_reset_a: got rst=%b busy=%b rep=%b prog=%h cnt=%0d, want reset values", a_core_reset, a_busy, a_report, a_prog_address, a_cycle_count);
        end
        n_cmp++;
        if ({b_core_reset, b_core_start, b_core_stall, b_prog_address, b_busy, b_done, b_timeout, b_report, b_cycle_count} !== c_RESET_VIEW) begin
            n_err++;
            $display("FAIL midrun_reset_b: got done=%b timeout=%b prog=%h cnt=%0d, want reset values", b_done, b_timeout, b_prog_address, b_cycle_count);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_cmp++;
            if ({a_report, a_busy, a_core_reset} !== 4'b0011) begin
                n_err++;
                $display("FAIL post_reset cycle %0d: got report=%b busy=%b rst=%b want report=0 busy=0 rst=11", i, a_report, a_busy, a_core_reset);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_launch();
        test_completion();
        test_stagger();
        test_timeout();
        test_priority();
        test_go_while_busy();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/core_launch_ctrl.md
CORE_LAUNCH_CTRL -- requirements
Module: core_launch_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2: number of cores launched and supervised.
REQ-002 SHALL have parameter ADDRESS_BITS, default 20: width of the program start address.
REQ-003 SHALL have parameter RESET_CYCLES, default 4: cycles for which core reset is held (minimum 1).
REQ-004 SHALL have parameter STAGGER_CYCLES, default 0: cycles between start pulses of consecutive cores.
REQ-005 SHALL have parameters STALL_PERIOD, default 8, and STALL_LEN, default 2: stall-injection pattern, with STALL_LEN < STALL_PERIOD.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum run length, where 0 disables the timeout.
REQ-007 SHALL have port clock, input, 1 bit: the single clock.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port go, input, 1 bit: launch request, sampled only in IDLE.
REQ-010 SHALL have port boot_address, input, ADDRESS_BITS bits: program start address, latched on an accepted go.
REQ-011 SHALL have port stall_en, input, 1 bit: enables stall injection during RUN.
REQ-012 SHALL have port core_done, input, NUM_CORES bits: per-core completion indication; a level or a one-cycle pulse are both valid.
REQ-013 SHALL have port core_reset, output, NUM_CORES bits: reset to each core.
REQ-014 SHALL have port core_start, output, NUM_CORES bits: one-cycle start pulse per core.
REQ-015 SHALL have port core_stall, output, 1 bit: stall_in for all cores.
REQ-016 SHALL have port prog_address, output, ADDRESS_BITS bits: the latched boot address.
REQ-017 SHALL have ports busy, done and timeout, each output, 1 bit: run status.
REQ-018 SHALL have port report, output, 1 bit: one-cycle pulse when a run ends.
REQ-019 SHALL have port cycle_count, output, 32 bits: length of the run in RUN cycles.

Function
REQ-020 SHALL implement the FSM states IDLE, HOLD, LAUNCH, RUN and END.
REQ-021 SHALL move from IDLE to HOLD on go=1, latching boot_address into prog_address and clearing done, timeout, cycle_count and the done-mask.
REQ-022 SHALL drive core_reset all-ones in IDLE and HOLD.
REQ-023 SHALL remain in HOLD for exactly RESET_CYCLES cycles, then go to LAUNCH with core_reset all-zeros.
REQ-024 SHALL, in LAUNCH, pulse core_start[i] for one cycle for i = 0..NUM_CORES-1, ascending, with STAGGER_CYCLES idle cycles between pulses (0 = consecutive cycles).
REQ-025 SHALL go to RUN in the cycle after the last start pulse.
REQ-026 SHALL increment cycle_count once per RUN cycle and saturate it at 0xFFFFFFFF.
REQ-027 SHALL, when stall_en=1 in RUN, assert core_stall for the first STALL_LEN cycles of every STALL_PERIOD-cycle window; the window counter starts at 0 on entry to RUN.
REQ-028 SHALL drive core_stall=0 outside RUN or when stall_en=0.
REQ-029 SHALL keep a sticky done-mask: bit i set when core_done[i]=1 in LAUNCH or RUN, cleared only by a new go or by reset.
REQ-030 SHALL go to END in the cycle after the done-mask becomes all-ones, or when cycle_count reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES non-zero).
REQ-031 SHALL give completion priority if completion and timeout occur in the same cycle: done=1, timeout=0.
REQ-032 SHALL, in END, pulse report for one cycle, set done or timeout, and return to IDLE the next cycle.
REQ-033 SHALL hold done and timeout until the next accepted go.
REQ-034 SHALL assert busy in HOLD, LAUNCH, RUN and END.
REQ-035 SHALL ignore go when not in IDLE.

Reset
REQ-036 SHALL, on reset=1, immediately and asynchronously enter IDLE.
REQ-037 SHALL reset outputs as: core_reset all-ones, core_start 0, core_stall 0, prog_address 0, busy 0, done 0, timeout 0, report 0, cycle_count 0.
REQ-038 SHALL, when reset is asserted mid-run, abort the run with no report pulse.

Structure
REQ-039 SHALL place the FSM state encoding and the saturating-counter width constant in the shared core package.
REQ-040 SHALL use one sub-module, stall_pattern_gen, holding the period/length counter and driving core_stall.

Verification
REQ-041 SHALL cover the default launch: NUM_CORES=2, go with boot_address=0x00100 -> core_reset high for 4 cycles, core_start[0] and core_start[1] in consecutive cycles, prog_address=0x00100.
REQ-042 SHALL cover staggered launch: STAGGER_CYCLES=3 -> start pulses 4 cycles apart.
REQ-043 SHALL cover stall injection: stall_en=1, period 8 / length 2 -> core_stall pattern 11000000 repeating from RUN entry.
REQ-044 SHALL cover completion: core_done[1] pulses at RUN cycle 5, core_done[0] at cycle 9 -> END, one-cycle report, done=1, cycle_count=10.
REQ-045 SHALL cover timeout: TIMEOUT_CYCLES=16, core_done never asserted -> timeout=1, done=0, one report pulse; with completion and timeout in the same cycle -> done=1, timeout=0.
REQ-046 SHALL cover mid-run reset and go-while-busy: reset during RUN -> all outputs at reset values, no report; go asserted in RUN -> ignored, prog_address unchanged.
